posit_mult_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined posit multiplier (`positmult`-style interface: `in1`/`in2`/`start` in, `result`/`inf`/`zero`/`done` out) among NREQ requesters in the PairHMM posit datapath. It accepts at most one operand pair per cycle and issues it to the multiplier. It tracks each in-flight operation with a tag pipeline and routes each result back to the requester that issued it. It also detects loss of alignment between issued operations and multiplier `done` pulses.

---
 rtl/posit_mult_arbiter_if.sv | 40 ++++
 rtl/posit_mult_arbiter.sv | 133 +++++++++++++
 tb/tb_posit_mult_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/posit_mult_arbiter_if.sv
// posit_mult_arbiter_if
//   Bundles the requester side, the multiplier side and the response side of
//   the shared posit multiplier arbiter.
//   slave  : the arbiter's view (requests and multiplier outputs come in;
//            grants, multiplier issue and responses go out).
//   master : the environment's view (requesters plus the multiplier).
//   Requester i owns bits [i*N +: N] of req_in1/req_in2.
interface posit_mult_arbiter_if #(
   parameter int N    = 32,
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_in1;
   logic [NREQ*N-1:0] req_in2;
   logic              mul_start;
   logic [N-1:0]      mul_in1;
   logic [N-1:0]      mul_in2;
   logic [N-1:0]      mul_result;
   logic              mul_inf;
   logic              mul_zero;
   logic              mul_done;
   logic [NREQ-1:0]   rsp_valid;
   logic [N-1:0]      rsp_result;
   logic              rsp_inf;
   logic              rsp_zero;
   logic              err_sync;

   modport slave (
      input  req_valid, req_in1, req_in2, mul_result, mul_inf, mul_zero, mul_done,
      output req_ready, mul_start, mul_in1, mul_in2,
             rsp_valid, rsp_result, rsp_inf, rsp_zero, err_sync
   );

   modport master (
      output req_valid, req_in1, req_in2, mul_result, mul_inf, mul_zero, mul_done,
      input  req_ready, mul_start, mul_in1, mul_in2,
             rsp_valid, rsp_result, rsp_inf, rsp_zero, err_sync
   );
endinterface

// File: rtl/posit_mult_arbiter.sv
// posit_mult_arbiter
//   Round-robin sharing of one fixed-latency pipelined posit multiplier among
//   NREQ requesters. One operand pair is granted per cycle, registered into the
//   multiplier, and its requester id rides a LAT-deep tag pipeline so that the
//   result arriving with mul_done is routed back as a one-hot rsp_valid.
//   A tag/done disagreement sets the sticky err_sync.
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   enable   1 = grants allowed, 0 = drain in-flight ops only
//   bus      posit_mult_arbiter_if.slave (requests, multiplier, responses)
module posit_mult_arbiter #(
   parameter int N    = 32,
   parameter int NREQ = 4,
   parameter int LAT  = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   posit_mult_arbiter_if.slave   bus
);
   localparam int IDW = $clog2(NREQ);
   localparam int GW  = $clog2(LAT + 2);

   logic [IDW-1:0]            ptr;
   logic [GW-1:0]             guard;
   logic                      guard_busy;
   logic [NREQ-1:0]           elig;
   logic                      gnt_any;
   logic [IDW-1:0]            win;
   logic [IDW:0]              sum;
   logic [IDW-1:0]            idx;
   logic [IDW-1:0]            iss_id;
   logic [LAT-1:0]            vld_pipe;
   logic [LAT-1:0][IDW-1:0]   id_pipe;
   logic                      tail_vld;
   logic [IDW-1:0]            tail_id;
   logic                      hit;

   // Guard window after reset: results of ops issued before the reset may
   // still come out of the multiplier, so grants, dones and errors are masked.
   assign guard_busy = (guard != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        guard <= GW'(LAT + 1);
      else if (guard_busy) guard <= guard - GW'(1);
   end

   // Round-robin pick: scan from ptr upward, wrapping modulo NREQ.
   assign elig = bus.req_valid & {NREQ{enable & ~guard_busy}};

   always_comb begin
      gnt_any = 1'b0;
      win     = '0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
         idx = sum[IDW-1:0];
         if (!gnt_any && elig[idx]) begin
            gnt_any = 1'b1;
            win     = idx;
         end
      end
   end

   assign bus.req_ready = gnt_any ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ptr <= '0;
      else if (gnt_any) ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
   end

   // Issue register: operands hold when nothing is issued.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.mul_start <= 1'b0;
         bus.mul_in1   <= '0;
         bus.mul_in2   <= '0;
         iss_id        <= '0;
      end else begin
         bus.mul_start <= gnt_any;
         if (gnt_any) begin
            bus.mul_in1 <= bus.req_in1[win*N +: N];
            bus.mul_in2 <= bus.req_in2[win*N +: N];
            iss_id      <= win;
         end
      end
   end

   // Tag pipeline: stage 0 captures the issue, the tail lines up with mul_done.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         id_pipe  <= '0;
      end else begin
         vld_pipe[0] <= bus.mul_start;
         id_pipe[0]  <= iss_id;
         for (int i = 1; i < LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            id_pipe[i]  <= id_pipe[i-1];
         end
      end
   end

   assign tail_vld = vld_pipe[LAT-1];
   assign tail_id  = id_pipe[LAT-1];
   assign hit      = tail_vld & bus.mul_done & ~guard_busy;

   // Response register; data holds between responses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.rsp_valid  <= '0;
         bus.rsp_result <= '0;
         bus.rsp_inf    <= 1'b0;
         bus.rsp_zero   <= 1'b0;
      end else begin
         bus.rsp_valid <= hit ? ({{(NREQ-1){1'b0}}, 1'b1} << tail_id) : '0;
         if (hit) begin
            bus.rsp_result <= bus.mul_result;
            bus.rsp_inf    <= bus.mul_inf;
            bus.rsp_zero   <= bus.mul_zero;
         end
      end
   end

   // Sticky: a done without a tag, or a tag without a done.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) bus.err_sync <= 1'b0;
      else if (!guard_busy && (tail_vld ^ bus.mul_done)) bus.err_sync <= 1'b1;
   end
endmodule

// File: tb/tb_posit_mult_arbiter.sv
module tb_posit_mult_arbiter;
   localparam int N     = 32;
   localparam int NREQ  = 4;
   localparam int LAT   = 4;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic enable = 1'b1;
   logic inject = 1'b0;

   always #5 clk = ~clk;

   posit_mult_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

   posit_mult_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .bus     (bus)
   );

   // Scripted product: {zero, inf, result}
   function automatic logic [33:0] prod_f(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      if (a == 32'hCEAA075E && b == 32'h9B95419C) return {2'b00, 32'h5A4F1B3C};
      r = a * b;
      return {a[1] & b[1], a[0] & b[0], r};
   endfunction

   // Multiplier model: fixed LAT, keeps running through reset.
   logic [LAT-1:0]        mv = '0;
   logic [LAT-1:0][33:0]  md = '0;
   always @(posedge clk) begin
      mv <= {mv[LAT-2:0], bus.mul_start};
      md <= {md[LAT-2:0], prod_f(bus.mul_in1, bus.mul_in2)};
   end
   assign bus.mul_done   = mv[LAT-1] | inject;
   assign bus.mul_result = md[LAT-1][31:0];
   assign bus.mul_inf    = md[LAT-1][32];
   assign bus.mul_zero   = md[LAT-1][33];

   // Reference model state
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rel = 0;
   int          ptr_m = 0;
   logic        err_exp = 1'b0;
   int          pend [NREQ];
   logic [31:0] op1 [NREQ];
   logic [31:0] op2 [NREQ];
   int          glog [$];
   logic [3:0]  exp_rv    [DEPTH];
   logic [33:0] exp_rsp   [DEPTH];
   logic        exp_start [DEPTH];
   logic [31:0] exp_in1   [DEPTH];
   logic [31:0] exp_in2   [DEPTH];
   logic [31:0] last_res = '0;
   logic        last_inf = 1'b0;
   logic        last_zero = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic clear_from(input int c);
      for (int i = c; i < DEPTH; i++) begin
         exp_rv[i] = '0; exp_rsp[i] = '0; exp_start[i] = 1'b0;
         exp_in1[i] = '0; exp_in2[i] = '0;
      end
   endtask

   // One clock: drive inputs, check outputs vs model, advance model.
   task automatic tick();
      int w;
      int id;
      logic [33:0] p;
      logic [3:0] exp_rdy;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i]       = (pend[i] > 0);
         bus.req_in1[i*N +: N]  = op1[i];
         bus.req_in2[i*N +: N]  = op2[i];
      end
      #1;
      w = -1;
      if (reset_n && enable && rel >= LAT + 1)
         for (int k = 0; k < NREQ; k++) begin
            id = (ptr_m + k) % NREQ;
            if (w < 0 && pend[id] > 0) w = id;
         end
      exp_rdy = (w >= 0) ? 4'(1 << w) : 4'b0;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("mul_start", 32'(bus.mul_start), 32'(exp_start[cyc]));
      if (exp_start[cyc]) begin
         chk("mul_in1", bus.mul_in1, exp_in1[cyc]);
         chk("mul_in2", bus.mul_in2, exp_in2[cyc]);
      end
      if (!reset_n) begin
         chk("reset_mul_in1", bus.mul_in1, 32'h0);
         chk("reset_mul_in2", bus.mul_in2, 32'h0);
      end
      if (exp_rv[cyc] != 4'b0) begin
         last_res  = exp_rsp[cyc][31:0];
         last_inf  = exp_rsp[cyc][32];
         last_zero = exp_rsp[cyc][33];
      end
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv[cyc]));
      chk("rsp_result", bus.rsp_result, last_res);
      chk("rsp_inf", 32'(bus.rsp_inf), 32'(last_inf));
      chk("rsp_zero", 32'(bus.rsp_zero), 32'(last_zero));
      chk("err_sync", 32'(bus.err_sync), 32'(err_exp));
      if (w >= 0) begin
         ptr_m = (w + 1) % NREQ;
         glog.push_back(w);
         exp_start[cyc+1] = 1'b1;
         exp_in1[cyc+1]   = op1[w];
         exp_in2[cyc+1]   = op2[w];
         p = prod_f(op1[w], op2[w]);
         exp_rv[cyc+LAT+2]  = 4'(1 << w);
         exp_rsp[cyc+LAT+2] = p;
      end
      @(negedge clk);
      if (w >= 0) begin
         pend[w]--;
         op1[w] = $urandom;
         op2[w] = $urandom;
      end
      cyc++;
      if (!reset_n) rel = 0;
      else rel++;
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      clear_from(cyc);
      ptr_m = 0; err_exp = 1'b0;
      last_res = '0; last_inf = 1'b0; last_zero = 1'b0;
      repeat (n) tick();
      reset_n = 1'b1;
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_in1   = '0;
      bus.req_in2   = '0;
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 0; op1[i] = $urandom; op2[i] = $urandom;
      end
      clear_from(0);
      @(negedge clk);
      do_reset(2);
      repeat (LAT + 2) tick();

      // Full load: 0,1,2,3 repeating, one per cycle
      glog.delete();
      for (int i = 0; i < NREQ; i++) pend[i] = 3;
      repeat (12) tick();
      chk("full_count", 32'(glog.size()), 32'd12);
      for (int i = 0; i < 12; i++)
         chk("full_order", (i < glog.size()) ? 32'(glog[i]) : 32'hFFFFFFFF, 32'(i % NREQ));
      repeat (LAT + 4) tick();

      // Single op with scripted product
      glog.delete();
      op1[0] = 32'hCEAA075E; op2[0] = 32'h9B95419C; pend[0] = 1;
      repeat (LAT + 6) tick();
      chk("single_count", 32'(glog.size()), 32'd1);
      chk("single_result", bus.rsp_result, 32'h5A4F1B3C);

      // Fairness: after 2, pending {1,3} -> 3 then 1
      glog.delete();
      pend[2] = 1;
      tick();
      pend[1] = 1; pend[3] = 1;
      repeat (3) tick();
      chk("fair_count", 32'(glog.size()), 32'd3);
      chk("fair_0", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFFFFFF, 32'd2);
      chk("fair_1", (glog.size() > 1) ? 32'(glog[1]) : 32'hFFFFFFFF, 32'd3);
      chk("fair_2", (glog.size() > 2) ? 32'(glog[2]) : 32'hFFFFFFFF, 32'd1);
      repeat (LAT + 4) tick();

      // Drain: 3 ops, then enable low with a requester still waiting
      pend[0] = 1; pend[1] = 1; pend[2] = 1;
      repeat (3) tick();
      enable = 1'b0;
      pend[3] = 2;
      glog.delete();
      repeat (10) tick();
      chk("drain_no_grant", 32'(glog.size()), 32'd0);
      enable = 1'b1;
      repeat (10) tick();

      // Misalignment: done with an empty tail
      inject = 1'b1;
      tick();
      inject = 1'b0;
      err_exp = 1'b1;
      repeat (6) tick();

      // Reset mid-flight
      for (int i = 0; i < NREQ; i++) pend[i] = 20;
      repeat (3) tick();
      do_reset(2);
      glog.delete();
      repeat (LAT + 1) tick();
      chk("guard_no_grant", 32'(glog.size()), 32'd0);
      tick();
      chk("guard_first_grant", 32'(glog.size()), 32'd1);
      repeat (6) tick();
      for (int i = 0; i < NREQ; i++) pend[i] = 0;
      repeat (LAT + 6) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
